// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module : aes_pkg
// Brief  : Shared widths and scheduler state encoding for the AES s_box sharing
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_STATE_W = 128;
  localparam int NB          = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/sub_bytes_sched_if.sv
//------------------------------------------------------------------------------
// Module : sub_bytes_sched_if
// Brief  : State and key-word request/response bundle for sub_bytes_sched
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sub_bytes_sched_if;
  import aes_pkg::*;

  logic                   st_valid;
  logic [AES_STATE_W-1:0] st_in;
  logic                   st_ready;
  logic                   st_done;
  logic [AES_STATE_W-1:0] st_out;
  logic                   kw_req;
  logic [AES_WORD_W-1:0]  kw_in;
  logic                   kw_done;
  logic [AES_WORD_W-1:0]  kw_out;
  logic                   busy;

  modport master (
    output st_valid, st_in, kw_req, kw_in,
    input  st_ready, st_done, st_out, kw_done, kw_out, busy
  );

  modport slave (
    input  st_valid, st_in, kw_req, kw_in,
    output st_ready, st_done, st_out, kw_done, kw_out, busy
  );

endinterface

`default_nettype wire

// File: rtl/sub_bytes_sched_s_box.sv
//------------------------------------------------------------------------------
// Module : s_box
// Brief  : Combinational AES forward S-box applied to all four bytes of a word
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module s_box (
  input  wire logic [31:0] row_in,
  output logic      [31:0] row_out
);

  // Entry 0x00 sits in the top byte, so byte b lives at bit offset 8*(255-b) = {~b,3'b0}
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return C_SBOX[{~b, 3'b000} +: 8];
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign row_out[8*i +: 8] = sub_byte(row_in[8*i +: 8]);
  end

endmodule

`default_nettype wire

// File: rtl/sub_bytes_sched.sv
//------------------------------------------------------------------------------
// Module : sub_bytes_sched
// Brief  : Shares one s_box row between state SubBytes and key SubWord requests
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub_bytes_sched #(
  parameter bit KEY_PRIO = 1'b1
) (
  input wire logic         clk,
  input wire logic         rst,
  sub_bytes_sched_if.slave bus
);
  import aes_pkg::*;

  sched_state_e           r_state;
  logic [1:0]             r_idx;
  logic [AES_STATE_W-1:0] r_st_cap;
  logic [AES_STATE_W-1:0] r_st_out;
  logic [AES_WORD_W-1:0]  r_kw_out;
  logic                   r_st_done;
  logic                   r_kw_done;

  logic                   w_key_grant;
  logic                   w_st_grant;
  logic [AES_WORD_W-1:0]  w_cap_word;
  logic [AES_WORD_W-1:0]  w_row_in;
  logic [AES_WORD_W-1:0]  w_row_out;

  // A key grant always raises kw_done next cycle, which blocks eligibility, so
  // two key grants can never be adjacent and the state op cannot starve.
  always_comb begin
    w_key_grant = bus.kw_req && !r_kw_done && ((r_state == IDLE) || KEY_PRIO);
    w_st_grant  = (r_state == RUN) && !w_key_grant;
    w_cap_word  = r_st_cap[127:96];
    case (r_idx)
      2'd1:    w_cap_word = r_st_cap[95:64];
      2'd2:    w_cap_word = r_st_cap[63:32];
      2'd3:    w_cap_word = r_st_cap[31:0];
      default: w_cap_word = r_st_cap[127:96];
    endcase
    w_row_in = w_key_grant ? bus.kw_in : w_cap_word;
  end

  s_box u_s_box (
    .row_in  (w_row_in),
    .row_out (w_row_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_st_cap  <= '0;
      r_st_out  <= '0;
      r_kw_out  <= '0;
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
    end else begin
      r_st_done <= 1'b0;
      r_kw_done <= w_key_grant;
      if (w_key_grant) begin
        r_kw_out <= w_row_out;
      end
      case (r_state)
        IDLE: begin
          if (bus.st_valid) begin
            r_st_cap <= bus.st_in;
            r_idx    <= 2'd0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (w_st_grant) begin
            case (r_idx)
              2'd0:    r_st_out[127:96] <= w_row_out;
              2'd1:    r_st_out[95:64]  <= w_row_out;
              2'd2:    r_st_out[63:32]  <= w_row_out;
              default: r_st_out[31:0]   <= w_row_out;
            endcase
            if (r_idx == 2'(NB - 1)) begin
              r_state   <= IDLE;
              r_st_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.st_ready = (r_state == IDLE);
  assign bus.busy     = (r_state == RUN);
  assign bus.st_done  = r_st_done;
  assign bus.st_out   = r_st_out;
  assign bus.kw_done  = r_kw_done;
  assign bus.kw_out   = r_kw_out;

endmodule

`default_nettype wire
